p405s_icu_va2_fill_seq: RTL and testbench
=========================================

// Module: p405s_icu_va2_fill_seq
// PURPOSE
// - Consumer side of the ICU VA2 address register: takes the latched 32-bit miss
//   address (VA2) and runs one critical-word-first cache-line fill on the PLB read side.
// - Writes each returned word into the I-cache data array and forwards the critical
//   word early to the fetch pipe.
// - One fill in flight at a time.
// PARAMETERS
// - LINE_WORDS  8  words per line; legal values 4 or 8
// - IDX_W       3  log2(LINE_WORDS); must match LINE_WORDS
// PORTS
// - CB             in   1      core clock; all state changes on the rising edge
// - ResetN         in   1      synchronous, active-low reset
// - missReq        in   1      VA2 holds a valid miss; held high until missAck
// - missVA2        in   0:31   registered VA2 address; bit 0 is the MSB
// - missAck        out  1      1-cycle pulse: miss accepted, VA2 may change
// - abort          in   1      fetch flush; cancel the current fill
// - plbReq         out  1      read request; held high until plbAddrAck
// - plbAddr        out  0:31   {missVA2[0:29],2'b00}; slave wraps the burst in the line
// - plbAddrAck     in   1      request accepted by the PLB
// - plbRdDValid    in   1      read data beat valid
// - plbRdData      in   0:31   read data beat
// - plbRdErr       in   1      beat error, qualified by plbRdDValid
// - fillWrEn       out  1      array write strobe
// - fillWrIdx      out  IDX_W  word index within the line
// - fillWrData     out  0:31   array write data
// - critWordVal    out  1      1-cycle pulse: critical word is valid
// - critWordData   out  0:31   critical word
// - fillDone       out  1      1-cycle pulse: fill complete
// - fillErr        out  1      with fillDone: one or more beats errored
// - fillBusy       out  1      state is not IDLE
// BEHAVIOUR
// - States: IDLE, REQ, DATA, DRAIN, DONE.
// - IDLE: on missReq, capture missVA2, pulse missAck, go to REQ next cycle.
// - REQ: plbReq=1, plbAddr stable. plbAddrAck clears the beat counter and goes to DATA.
//   - abort before plbAddrAck: drop plbReq next cycle, return to IDLE, no fillDone.
//   - plbAddrAck and abort in the same cycle: the ack wins; go to DRAIN.
// - DATA: each plbRdDValid beat is one word.
//   - fillWrIdx = (startIdx + beatCnt) mod LINE_WORDS.
//   - startIdx = VA2 word bits [30-IDX_W:29]; for IDX_W=3 that is VA2[27:29].
//   - Write path is registered: fillWrEn/fillWrIdx/fillWrData appear 1 cycle after the beat.
//   - First good beat (beatCnt==0): critWordVal pulses with fillWrEn, same data.
//   - Beat with plbRdErr: no write, set the sticky err flag, go to DRAIN.
//     No critWordVal if the error is on beat 0.
//   - abort in DATA: go to DRAIN; a beat in the same cycle is not written.
//   - Last beat (beatCnt==LINE_WORDS-1) good: go to DONE.
// - DRAIN: count the remaining beats with no writes and no critWordVal.
//   After the last beat go to DONE.
// - DONE: fillDone=1 for 1 cycle, fillErr=err flag, then IDLE.
//   - fillDone asserts 1 cycle after the final write; aborted fills also signal fillDone.
//   - missReq is not accepted in DONE; earliest re-accept is the following IDLE cycle.
// - beatCnt is IDX_W+1 bits wide and never exceeds LINE_WORDS.
// - plbRdDValid outside DATA/DRAIN is ignored.
// - Index wrap: the start index LINE_WORDS-1 is followed by 0.
// - Reset (ResetN=0 at an edge): state=IDLE, all outputs 0, err flag cleared, beatCnt=0.
//   - Applies mid-fill; beats still on the bus after reset are ignored in IDLE.
// TESTING
// - Aligned miss, VA2=0x0000_1000, no wait states:
//   - writes idx 0..7, data D0..D7; critWordVal with D0; fillDone 1 cycle after idx 7.
// - Wrap case, VA2=0x0000_101C:
//   - plbAddr=0x0000_101C; idx order 7,0,1,..,6; critWordVal at idx 7.
// - Gapped beats (plbRdDValid on alternate cycles), VA2=0x2000_0008:
//   - writes idx 2..7,0,1, one per beat; fillBusy stays high throughout.
// - plbRdErr on beat 3, VA2=0x0:
//   - writes idx 0,1,2 only; beats 3..7 drained; fillDone=1 with fillErr=1.
// - abort in REQ before plbAddrAck:
//   - plbReq drops next cycle, no fillDone, back to IDLE.
// - abort in DATA after beat 2, then ResetN=0 mid-drain:
//   - no further writes; all outputs 0 next cycle; a new missReq is accepted after reset.

Source files
------------

// File: rtl/p405s_icu_va2_fill_seq.sv
// p405s_icu_va2_fill_seq
// Consumes the latched VA2 miss address and runs one critical-word-first
// cache-line fill on the PLB read side. Each returned word is written into the
// I-cache data array. The critical word (the first beat) is also forwarded to
// the fetch pipe. Only one fill is in flight at a time.
//
// Ports (bit 0 is the MSB on all 0:31 buses)
//   CB            core clock, rising edge
//   ResetN        synchronous active-low reset
//   missReq       VA2 holds a valid miss, held until missAck
//   missVA2       registered miss address
//   missAck       1-cycle accept pulse; VA2 may change afterwards
//   abort         fetch flush, cancels the current fill
//   plbReq        read request, held until plbAddrAck
//   plbAddr       word-aligned miss address; slave wraps the burst in the line
//   plbAddrAck    request accepted
//   plbRdDValid   read beat valid
//   plbRdData     read beat data
//   plbRdErr      beat error, qualified by plbRdDValid
//   fillWrEn      array write strobe (one cycle after the beat)
//   fillWrIdx     word index within the line
//   fillWrData    array write data
//   critWordVal   critical word valid pulse, coincident with its array write
//   critWordData  critical word
//   fillDone      1-cycle completion pulse, one cycle after the final write
//   fillErr       with fillDone: at least one beat errored
//   fillBusy      sequencer is not idle
//
// state | meaning
// IDLE  | waiting for missReq
// REQ   | plbReq asserted, waiting for plbAddrAck
// DATA  | beats written to the array
// DRAIN | remaining beats counted and discarded (error or abort)
// DONE  | fill finished, fillDone issued on the next cycle

module p405s_icu_va2_fill_seq #(
   parameter int LINE_WORDS = 8,
   parameter int IDX_W      = 3
) (
   input  logic             CB,
   input  logic             ResetN,
   input  logic             missReq,
   input  logic [0:31]      missVA2,
   output logic             missAck,
   input  logic             abort,
   output logic             plbReq,
   output logic [0:31]      plbAddr,
   input  logic             plbAddrAck,
   input  logic             plbRdDValid,
   input  logic [0:31]      plbRdData,
   input  logic             plbRdErr,
   output logic             fillWrEn,
   output logic [IDX_W-1:0] fillWrIdx,
   output logic [0:31]      fillWrData,
   output logic             critWordVal,
   output logic [0:31]      critWordData,
   output logic             fillDone,
   output logic             fillErr,
   output logic             fillBusy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DATA,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [IDX_W:0] LAST_BEAT = (IDX_W+1)'(LINE_WORDS-1);

   state_t           state;
   state_t           state_nxt;
   logic [0:31]      va2_q;
   logic [IDX_W:0]   beat_cnt;
   logic             err_q;
   logic [IDX_W-1:0] start_idx;
   logic             accept;
   logic             in_burst;
   logic             last_beat;
   logic             good_beat;

   assign start_idx = va2_q[30-IDX_W:29];
   assign accept    = (state == S_IDLE) && missReq;
   assign in_burst  = (state == S_DATA) || (state == S_DRAIN);
   assign last_beat = (beat_cnt == LAST_BEAT);
   // a beat that coincides with an abort or carries an error is never written
   assign good_beat = (state == S_DATA) && plbRdDValid && !plbRdErr && !abort;

   assign plbReq   = (state == S_REQ);
   assign plbAddr  = {va2_q[0:29], 2'b00};
   assign fillBusy = (state != S_IDLE);

   always_ff @(posedge CB) begin
      if (!ResetN) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (missReq) state_nxt = S_REQ;
         // an ack in the same cycle as abort still commits the burst, so it must be drained
         S_REQ: begin
            if (plbAddrAck)  state_nxt = abort ? S_DRAIN : S_DATA;
            else if (abort)  state_nxt = S_IDLE;
         end
         // the last beat ends the burst whatever it carries; nothing is left to drain
         S_DATA: begin
            if (plbRdDValid && last_beat)                state_nxt = S_DONE;
            else if (abort || (plbRdDValid && plbRdErr)) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (plbRdDValid && last_beat) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CB) begin
      if (!ResetN) begin
         va2_q        <= '0;
         beat_cnt     <= '0;
         err_q        <= 1'b0;
         missAck      <= 1'b0;
         fillWrEn     <= 1'b0;
         fillWrIdx    <= '0;
         fillWrData   <= '0;
         critWordVal  <= 1'b0;
         critWordData <= '0;
         fillDone     <= 1'b0;
         fillErr      <= 1'b0;
      end else begin
         missAck     <= accept;
         fillWrEn    <= good_beat;
         critWordVal <= good_beat && (beat_cnt == '0);
         fillDone    <= (state == S_DONE);
         fillErr     <= (state == S_DONE) && err_q;
         if (accept) begin
            va2_q    <= missVA2;
            err_q    <= 1'b0;
            beat_cnt <= '0;
         end
         if ((state == S_REQ) && plbAddrAck) beat_cnt <= '0;
         // counter stops at LINE_WORDS: the last beat always leaves DATA/DRAIN
         if (in_burst && plbRdDValid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (plbRdErr) err_q <= 1'b1;
         end
         if (good_beat) begin
            fillWrIdx  <= start_idx + beat_cnt[IDX_W-1:0];
            fillWrData <= plbRdData;
         end
         if (good_beat && (beat_cnt == '0)) critWordData <= plbRdData;
      end
   end

endmodule

// File: tb/tb_p405s_icu_va2_fill_seq.sv
module tb_p405s_icu_va2_fill_seq;

   logic        CB = 1'b0;
   logic        ResetN = 1'b0;
   logic        missReq = 1'b0;
   logic [0:31] missVA2 = '0;
   logic        missAck;
   logic        abort = 1'b0;
   logic        plbReq;
   logic [0:31] plbAddr;
   logic        plbAddrAck = 1'b0;
   logic        plbRdDValid = 1'b0;
   logic [0:31] plbRdData = '0;
   logic        plbRdErr = 1'b0;
   logic        fillWrEn;
   logic [2:0]  fillWrIdx;
   logic [0:31] fillWrData;
   logic        critWordVal;
   logic [0:31] critWordData;
   logic        fillDone;
   logic        fillErr;
   logic        fillBusy;

   p405s_icu_va2_fill_seq #(.LINE_WORDS(8), .IDX_W(3)) dut (
      .CB(CB), .ResetN(ResetN), .missReq(missReq), .missVA2(missVA2), .missAck(missAck),
      .abort(abort), .plbReq(plbReq), .plbAddr(plbAddr), .plbAddrAck(plbAddrAck),
      .plbRdDValid(plbRdDValid), .plbRdData(plbRdData), .plbRdErr(plbRdErr),
      .fillWrEn(fillWrEn), .fillWrIdx(fillWrIdx), .fillWrData(fillWrData),
      .critWordVal(critWordVal), .critWordData(critWordData),
      .fillDone(fillDone), .fillErr(fillErr), .fillBusy(fillBusy)
   );

   always #5 CB = ~CB;

   int cyc = 0;
   always @(posedge CB) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // observed events, sampled on the falling edge
   int          wr_idx[$];
   logic [31:0] wr_dat[$];
   int          wr_cyc[$];
   logic [31:0] crit_dat[$];
   bit          crit_co[$];
   int          done_cyc[$];
   bit          done_err[$];

   always @(negedge CB) begin
      if (fillWrEn === 1'b1) begin
         wr_idx.push_back(int'(fillWrIdx));
         wr_dat.push_back(fillWrData);
         wr_cyc.push_back(cyc);
      end
      if (critWordVal === 1'b1) begin
         crit_dat.push_back(critWordData);
         crit_co.push_back(fillWrEn === 1'b1 && fillWrData === critWordData);
      end
      if (fillDone === 1'b1) begin
         done_cyc.push_back(cyc);
         done_err.push_back(fillErr === 1'b1);
      end
   end

   task automatic clear_mon();
      wr_idx.delete(); wr_dat.delete(); wr_cyc.delete();
      crit_dat.delete(); crit_co.delete();
      done_cyc.delete(); done_err.delete();
   endtask

   logic [31:0] d[8];
   int          beat_edge[8];

   task automatic drive_idle();
      plbAddrAck  = 1'b0;
      plbRdDValid = 1'b0;
      plbRdErr    = 1'($urandom);
      plbRdData   = $urandom;
      abort       = 1'b0;
   endtask

   task automatic beat(input logic [31:0] dat, input bit err, input bit ab);
      drive_idle();
      plbRdDValid = 1'b1;
      plbRdData   = dat;
      plbRdErr    = err;
      abort       = ab;
      @(negedge CB);
   endtask

   task automatic accept(input logic [31:0] va2, output bit ok);
      ok = 1'b0;
      drive_idle();
      missReq = 1'b1;
      missVA2 = va2;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge CB);
         if (missAck === 1'b1) ok = 1'b1;
      end
      missReq = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_missAck"}, missAck, 0);
      chk({tag, "_plbReq"}, plbReq, 0);
      chk({tag, "_plbAddr"}, plbAddr, 0);
      chk({tag, "_wrEn"}, fillWrEn, 0);
      chk({tag, "_wrIdx"}, fillWrIdx, 0);
      chk({tag, "_wrData"}, fillWrData, 0);
      chk({tag, "_critVal"}, critWordVal, 0);
      chk({tag, "_critData"}, critWordData, 0);
      chk({tag, "_done"}, fillDone, 0);
      chk({tag, "_err"}, fillErr, 0);
      chk({tag, "_busy"}, fillBusy, 0);
   endtask

   // abort_b < 0 means abort asserted together with plbAddrAck; 8 means no abort / no error
   task automatic run_fill(input logic [31:0] va2, input int gap, input int err_b,
                           input int abort_b, input int ack_dly, input bit rnd,
                           output int n_wr, output int first_idx, output int err_out);
      int stop, start, g, busy_bad, req_bad;
      bit ok;
      clear_mon();
      for (int b = 0; b < 8; b++) d[b] = rnd ? $urandom : 32'hD000_0000 + 32'(b);
      accept(va2, ok);
      chk("accept", 32'(ok), 1);
      chk("plb_req", plbReq, 1);
      chk("plb_addr", plbAddr, va2 & 32'hFFFF_FFFC);
      missVA2 = $urandom;
      req_bad = 0;
      busy_bad = 0;
      for (int i = 0; i < ack_dly; i++) begin
         drive_idle();
         plbRdDValid = 1'($urandom);
         @(negedge CB);
         if (plbReq !== 1'b1 || plbAddr !== (va2 & 32'hFFFF_FFFC)) req_bad++;
      end
      drive_idle();
      plbRdDValid = 1'($urandom);
      plbAddrAck  = 1'b1;
      abort       = (abort_b < 0);
      @(negedge CB);
      chk("ack_pulse", missAck, 0);
      chk("req_hold", 32'(req_bad), 0);
      for (int b = 0; b < 8; b++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int i = 0; i < g; i++) begin
            drive_idle();
            @(negedge CB);
            if (fillBusy !== 1'b1) busy_bad++;
         end
         beat_edge[b] = cyc + 1;
         beat(d[b], b == err_b, b == abort_b);
         if (fillBusy !== 1'b1) busy_bad++;
      end
      drive_idle();
      for (int i = 0; i < 6 && done_cyc.size() == 0; i++) @(negedge CB);
      repeat (2) @(negedge CB);
      chk("busy", 32'(busy_bad), 0);

      // reference: beats before the first error/abort are written in wrapped order
      start = int'((va2 >> 2) & 32'h7);
      stop = 8;
      if (err_b < stop) stop = err_b;
      if (abort_b < stop) stop = (abort_b < 0) ? 0 : abort_b;
      chk("n_writes", 32'(wr_idx.size()), 32'(stop));
      for (int k = 0; k < stop && k < wr_idx.size(); k++) begin
         chk("wr_idx", 32'(wr_idx[k]), 32'((start + k) % 8));
         chk("wr_data", wr_dat[k], d[k]);
         chk("wr_time", 32'(wr_cyc[k]), 32'(beat_edge[k]));
      end
      chk("crit_n", 32'(crit_dat.size()), (stop > 0) ? 1 : 0);
      if (stop > 0 && crit_dat.size() > 0) begin
         chk("crit_data", crit_dat[0], d[0]);
         chk("crit_with_wr", 32'(crit_co[0]), 1);
      end
      chk("done_n", 32'(done_cyc.size()), 1);
      if (done_cyc.size() > 0) begin
         chk("done_err", 32'(done_err[0]), (err_b < 8) ? 1 : 0);
         chk("done_time", 32'(done_cyc[0]), 32'(beat_edge[7] + 1));
      end
      n_wr      = wr_idx.size();
      first_idx = (n_wr > 0) ? wr_idx[0] : -1;
      err_out   = (done_err.size() > 0) ? int'(done_err[0]) : -1;
   endtask

   typedef struct {
      logic [31:0] va2;
      int gap;
      int err_b;
      int abort_b;
      int ack_dly;
      int exp_nwr;
      int exp_first;
      int exp_err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n_wr, first_idx, err_out, eb, ab, r;
      bit ok;

      tbl[0] = '{32'h0000_1000, 0, 8, 8, 0, 8, 0, 0};
      tbl[1] = '{32'h0000_101C, 0, 8, 8, 1, 8, 7, 0};
      tbl[2] = '{32'h2000_0008, 1, 8, 8, 0, 8, 2, 0};
      tbl[3] = '{32'h0000_0000, 0, 3, 8, 2, 3, 0, 1};
      tbl[4] = '{32'h0000_0014, 2, 0, 8, 0, 0, -1, 1};
      tbl[5] = '{32'h0000_001C, 0, 8, 5, 0, 5, 7, 0};
      tbl[6] = '{32'hFFFF_FFFC, 0, 7, 8, 3, 7, 7, 1};
      tbl[7] = '{32'h0000_0010, 0, 8, 7, 0, 7, 4, 0};
      tbl[8] = '{32'h0000_000C, 0, 8, -1, 0, 0, -1, 0};

      drive_idle();
      repeat (3) @(negedge CB);
      chk_zero("reset");
      ResetN = 1'b1;
      @(negedge CB);

      for (int t = 0; t < 9; t++) begin
         run_fill(tbl[t].va2, tbl[t].gap, tbl[t].err_b, tbl[t].abort_b, tbl[t].ack_dly, 1'b0,
                  n_wr, first_idx, err_out);
         chk($sformatf("tbl%0d_nwr", t), 32'(n_wr), 32'(tbl[t].exp_nwr));
         if (tbl[t].exp_first >= 0) chk($sformatf("tbl%0d_first", t), 32'(first_idx), 32'(tbl[t].exp_first));
         chk($sformatf("tbl%0d_err", t), 32'(err_out), 32'(tbl[t].exp_err));
      end

      // abort while waiting for the address ack
      clear_mon();
      accept(32'h0000_0040, ok);
      chk("areq_accept", 32'(ok), 1);
      drive_idle();
      abort = 1'b1;
      @(negedge CB);
      drive_idle();
      chk("areq_plbReq", plbReq, 0);
      chk("areq_busy", fillBusy, 0);
      repeat (5) @(negedge CB);
      chk("areq_nodone", 32'(done_cyc.size()), 0);

      // abort in DATA after beat 2, then reset while draining
      clear_mon();
      accept(32'h0000_0100, ok);
      chk("arst_accept", 32'(ok), 1);
      drive_idle();
      plbAddrAck = 1'b1;
      @(negedge CB);
      for (int b = 0; b < 3; b++) beat(32'hA000_0000 + 32'(b), 1'b0, 1'b0);
      drive_idle();
      abort = 1'b1;
      @(negedge CB);
      beat(32'hA000_0003, 1'b0, 1'b0);
      beat(32'hA000_0004, 1'b0, 1'b0);
      drive_idle();
      plbRdDValid = 1'b1;
      ResetN = 1'b0;
      @(negedge CB);
      ResetN = 1'b1;
      chk_zero("midrst");
      beat(32'hA000_0006, 1'b0, 1'b0);
      beat(32'hA000_0007, 1'b0, 1'b0);
      drive_idle();
      repeat (4) @(negedge CB);
      chk("arst_nwr", 32'(wr_idx.size()), 3);
      chk("arst_nodone", 32'(done_cyc.size()), 0);
      chk("arst_busy", fillBusy, 0);
      run_fill(32'h0000_1004, 0, 8, 8, 0, 1'b1, n_wr, first_idx, err_out);
      chk("arst_refill_first", 32'(first_idx), 1);

      // randomized fills against the reference
      for (int t = 0; t < 40; t++) begin
         r  = int'($urandom_range(0, 9));
         eb = (r < 3) ? int'($urandom_range(0, 7)) : 8;
         r  = int'($urandom_range(0, 9));
         ab = (r == 0) ? -1 : (r < 3) ? int'($urandom_range(0, 7)) : 8;
         run_fill($urandom, -1, eb, ab, int'($urandom_range(0, 3)), 1'b1, n_wr, first_idx, err_out);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
